// File: rtl/operand_fetch_stage_if.sv
// Operand fetch stage bus bundle: decoded instruction in, register file read
// port, EX/WB hazard and bypass information, and the ID/EX output handshake.
// master = upstream/environment side, slave = operand_fetch_stage.
interface operand_fetch_stage_if #(
    parameter int DW  = 16,
    parameter int RW  = 4,
    parameter int OPW = 4
);
    // decoded instruction from ID
    logic           in_valid;
    logic           in_ready;
    logic [RW-1:0]  in_rs1;
    logic [RW-1:0]  in_rs2;
    logic [RW-1:0]  in_rd;
    logic [OPW-1:0] in_opcode;
    logic [DW-1:0]  in_imm;
    logic           in_reg_write;
    logic           in_mem_read;
    // register file read port
    logic [RW-1:0]  rf_read_reg1;
    logic [RW-1:0]  rf_read_reg2;
    logic [DW-1:0]  rf_read_data1;
    logic [DW-1:0]  rf_read_data2;
    // instruction currently in EX
    logic           ex_reg_write;
    logic           ex_mem_read;
    logic [RW-1:0]  ex_rd;
    logic [DW-1:0]  ex_result;
    // register file writeback this cycle
    logic           wb_reg_write;
    logic [RW-1:0]  wb_write_reg;
    logic [DW-1:0]  wb_write_data;
    // branch/jump squash
    logic           flush;
    // ID/EX register towards EX
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_op_a;
    logic [DW-1:0]  out_op_b;
    logic [RW-1:0]  out_rd;
    logic [OPW-1:0] out_opcode;
    logic [DW-1:0]  out_imm;
    logic           out_reg_write;
    logic           out_mem_read;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_opcode, in_imm, in_reg_write, in_mem_read,
        output rf_read_data1, rf_read_data2,
        output ex_reg_write, ex_mem_read, ex_rd, ex_result,
        output wb_reg_write, wb_write_reg, wb_write_data,
        output flush, out_ready,
        input  in_ready, rf_read_reg1, rf_read_reg2,
        input  out_valid, out_op_a, out_op_b, out_rd, out_opcode, out_imm, out_reg_write, out_mem_read
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_opcode, in_imm, in_reg_write, in_mem_read,
        input  rf_read_data1, rf_read_data2,
        input  ex_reg_write, ex_mem_read, ex_rd, ex_result,
        input  wb_reg_write, wb_write_reg, wb_write_data,
        input  flush, out_ready,
        output in_ready, rf_read_reg1, rf_read_reg2,
        output out_valid, out_op_a, out_op_b, out_rd, out_opcode, out_imm, out_reg_write, out_mem_read
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch stage of the 16-bit CPU.
// Drives register file read addresses, resolves RAW hazards and holds the
// result in the ID/EX register behind a valid/ready handshake.
// Build option OFS_FORWARD_EN: when defined, operands are forwarded from EX
// and WB and only load-use hazards stall; when undefined, any RAW match
// against EX or WB stalls and operands come from the register file only.
module operand_fetch_stage #(
    parameter int DW  = 16,
    parameter int RW  = 4,
    parameter int OPW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_fetch_stage_if.slave  bus
);
    typedef enum logic {RUN, BUBBLE} state_t;

    state_t         state, state_next;
    logic           adv;
    logic           stall;
    logic           ready;
    logic           capture;
    logic           ex_hit;
    logic           wb_hit;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;

    logic           vld_p1;
    logic [DW-1:0]  op_a_p1;
    logic [DW-1:0]  op_b_p1;
    logic [RW-1:0]  rd_p1;
    logic [OPW-1:0] opcode_p1;
    logic [DW-1:0]  imm_p1;
    logic           reg_write_p1;
    logic           mem_read_p1;

    assign bus.rf_read_reg1 = bus.in_rs1;
    assign bus.rf_read_reg2 = bus.in_rs2;

    // Register 0 is hard-zero, so a write to it never creates a dependency.
    assign ex_hit = bus.ex_reg_write && (bus.ex_rd != '0) &&
                    ((bus.ex_rd == bus.in_rs1) || (bus.ex_rd == bus.in_rs2));
    assign wb_hit = bus.wb_reg_write && (bus.wb_write_reg != '0) &&
                    ((bus.wb_write_reg == bus.in_rs1) || (bus.wb_write_reg == bus.in_rs2));

`ifdef OFS_FORWARD_EN
    // Forward priority: zero register, then EX (non-load), then WB, then RF.
    function automatic logic [DW-1:0] resolve(
        input logic [RW-1:0] rs,      input logic [DW-1:0] rf_data,
        input logic          ex_fwd,  input logic [RW-1:0] ex_rd,  input logic [DW-1:0] ex_data,
        input logic          wb_fwd,  input logic [RW-1:0] wb_rd,  input logic [DW-1:0] wb_data);
        if (rs == '0)                return '0;
        if (ex_fwd && (ex_rd == rs)) return ex_data;
        if (wb_fwd && (wb_rd == rs)) return wb_data;
        return rf_data;
    endfunction

    // A load in EX has no data yet; everything else is covered by bypasses.
    assign stall = bus.in_valid && ex_hit && bus.ex_mem_read;
    assign op_a  = resolve(bus.in_rs1, bus.rf_read_data1,
                           bus.ex_reg_write && !bus.ex_mem_read, bus.ex_rd, bus.ex_result,
                           bus.wb_reg_write, bus.wb_write_reg, bus.wb_write_data);
    assign op_b  = resolve(bus.in_rs2, bus.rf_read_data2,
                           bus.ex_reg_write && !bus.ex_mem_read, bus.ex_rd, bus.ex_result,
                           bus.wb_reg_write, bus.wb_write_reg, bus.wb_write_data);
`else
    logic unused_fwd;

    // Without bypass paths every pending write to a source must drain first.
    assign stall      = bus.in_valid && (ex_hit || wb_hit);
    assign op_a       = (bus.in_rs1 == '0) ? '0 : bus.rf_read_data1;
    assign op_b       = (bus.in_rs2 == '0) ? '0 : bus.rf_read_data2;
    assign unused_fwd = ^{bus.ex_result, bus.ex_mem_read, bus.wb_write_data};
`endif

    assign adv          = !vld_p1 || bus.out_ready;
    assign bus.in_ready = ready;
    assign capture      = bus.in_valid && ready;

    // Next state and input acceptance; a flush squashes acceptance and any pending bubble.
    always_comb begin
        state_next = state;
        ready      = adv && !stall && (state == RUN) && !bus.flush;
        if (bus.flush) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:     if (stall && adv) state_next = BUBBLE;
                BUBBLE:  state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // ID/EX register: capture on accept, drop to a bubble on advance, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            op_a_p1      <= '0;
            op_b_p1      <= '0;
            rd_p1        <= '0;
            opcode_p1    <= '0;
            imm_p1       <= '0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= capture;
            if (capture) begin
                op_a_p1      <= op_a;
                op_b_p1      <= op_b;
                rd_p1        <= bus.in_rd;
                opcode_p1    <= bus.in_opcode;
                imm_p1       <= bus.in_imm;
                reg_write_p1 <= bus.in_reg_write;
                mem_read_p1  <= bus.in_mem_read;
            end
        end
    end

    assign bus.out_valid     = vld_p1;
    assign bus.out_op_a      = op_a_p1;
    assign bus.out_op_b      = op_b_p1;
    assign bus.out_rd        = rd_p1;
    assign bus.out_opcode    = opcode_p1;
    assign bus.out_imm       = imm_p1;
    assign bus.out_reg_write = reg_write_p1;
    assign bus.out_mem_read  = mem_read_p1;
endmodule
